// File: rtl/resto_pkg.sv
// Shared types and helpers for the bit-serial modulo unit and its single-step datapath.
package resto_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } resto_estado_t;

    function automatic int RESTO_W(input int d);
        return $clog2(d);
    endfunction

endpackage

// File: rtl/resto_passo.sv
// One restoring-division step: r_next = (2r+b) mod DIVISOR, q_bit = (2r+b) >= DIVISOR.
// Purely combinational; r must already be below DIVISOR.
module resto_passo
    import resto_pkg::*;
#(
    parameter int  DIVISOR = 5,
    localparam int RW      = RESTO_W(DIVISOR)
) (
    input  logic [RW-1:0] r,
    input  logic          b,
    output logic [RW-1:0] r_next,
    output logic          q_bit
);

    // DIVISOR can equal 2^RW, so it needs the extra bit of t to compare.
    localparam logic [RW:0] D_T = DIVISOR[RW:0];

    logic [RW:0] t;

    always_comb begin
        t      = {r, b};
        r_next = t[RW-1:0];
        q_bit  = 1'b0;
        if (t >= D_T) begin
            r_next = RW'(t - D_T);
            q_bit  = 1'b1;
        end
    end

endmodule

// File: rtl/resto_serial.sv
// Bit-serial sensor mod DIVISOR, MSB first: WIDTH cycles of latency, one operand in flight, result held until resto_ready.
// Optional quotient output enabled by defining RESTO_QUOCIENTE_EN.
module resto_serial
    import resto_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  DIVISOR = 5,
    localparam int RW      = RESTO_W(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_valid,
    output logic             sensor_ready,
    input  logic [WIDTH-1:0] sensor,
    output logic             resto_valid,
    input  logic             resto_ready,
`ifdef RESTO_QUOCIENTE_EN
    output logic [WIDTH-1:0] quociente,
`endif
    output logic [RW-1:0]    resto
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2 || DIVISOR < 2 || longint'(DIVISOR) > (longint'(1) << WIDTH)) begin : g_param_err
        $error("resto_serial: WIDTH must be >= 2 and DIVISOR in 2..2^WIDTH");
    end

    resto_estado_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [RW-1:0]    r_q, r_d;
    logic [RW-1:0]    r_step;
    logic             q_bit;

    resto_passo #(
        .DIVISOR (DIVISOR)
    ) u_passo (
        .r      (r_q),
        .b      (sh_q[WIDTH-1]),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

`ifdef RESTO_QUOCIENTE_EN
    logic [WIDTH-1:0] q_q, q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    always_comb begin
        q_d = q_q;
        if (state_q == IDLE && sensor_valid) q_d = '0;
        else if (state_q == CALC)            q_d = {q_q[WIDTH-2:0], q_bit};
    end

    assign quociente = q_q;
`else
    logic unused_q_bit;
    assign unused_q_bit = q_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        r_d          = r_q;
        sensor_ready = 1'b0;
        resto_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                sensor_ready = 1'b1;
                if (sensor_valid) begin
                    sh_d    = sensor;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d  = r_step;
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE: begin
                resto_valid = 1'b1;
                if (resto_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // r_q is untouched in DONE, so the result is stable while it waits.
    assign resto = r_q;

endmodule

// File: tb/tb_resto_serial.sv
// Randomised and directed bench for resto_serial with a queue scoreboard against plain % and / arithmetic.
module tb_resto_serial;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int RW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          sensor_valid;
    logic          sensor_ready;
    logic [W-1:0]  sensor;
    logic          resto_valid;
    logic          resto_ready;
    logic [RW-1:0] resto;
`ifdef RESTO_QUOCIENTE_EN
    logic [W-1:0]  quociente;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_results = 0;

    typedef struct {
        int r;
        int q;
        int acc;
    } exp_t;

    exp_t sb[$];

    resto_serial #(
        .WIDTH   (W),
        .DIVISOR (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_valid (sensor_valid),
        .sensor_ready (sensor_ready),
        .sensor       (sensor),
        .resto_valid  (resto_valid),
        .resto_ready  (resto_ready),
`ifdef RESTO_QUOCIENTE_EN
        .quociente    (quociente),
`endif
        .resto        (resto)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on the rising edge of resto_valid, value on the result handshake.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (resto_valid && !prev_vld) begin
                if (sb.size() == 0) chk("spurious_result", 1, 0);
                else                chk("latency", cyc, sb[0].acc + W);
            end
            if (resto_valid && resto_ready && sb.size() > 0) begin
                e = sb.pop_front();
                n_results++;
                chk("resto", resto, e.r);
`ifdef RESTO_QUOCIENTE_EN
                chk("quociente", quociente, e.q);
`endif
            end
            prev_vld = resto_valid;
        end
    end

    task automatic send(input logic [W-1:0] v, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        sensor       = v;
        sensor_valid = 1'b1;
        while (!sensor_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        acc = cyc + 1;
        if (!sensor_ready) chk("accept_timeout", 0, 1);
        else               sb.push_back('{int'(v) % D, int'(v) / D, acc});
        @(posedge clk);
        #1;
        sensor_valid = 1'b0;
        sensor       = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sensor_ready"}, sensor_ready, 1);
        chk({tag, "_resto_valid"}, resto_valid, 0);
        chk({tag, "_resto"}, resto, 0);
`ifdef RESTO_QUOCIENTE_EN
        chk({tag, "_quociente"}, quociente, 0);
`endif
    endtask

    initial begin
        int acc;
        int prev_acc;
        int t;
        int nv;
        logic [W-1:0] v;

        rst          = 1'b1;
        sensor_valid = 1'b0;
        sensor       = '0;
        resto_ready  = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner values
        send(W'(13), acc);
        send(W'(255), acc);
        send(W'(0), acc);

        // Back-to-back with consumer always ready: spacing must be W+2
        for (int i = 0; i < 16; i++) begin
            send(W'(i), acc);
            if (i > 0) chk("initiation_interval", acc - prev_acc, W + 2);
            prev_acc = acc;
        end

        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), acc);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Backpressure
        repeat (2 * W) @(negedge clk);
        resto_ready = 1'b0;
        v = W'($urandom);
        send(v, acc);
        t = 0;
        while (!resto_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", resto_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_held", resto_valid, 1);
            chk("bp_resto_stable", resto, int'(v) % D);
            chk("bp_sensor_ready_low", sensor_ready, 0);
            sensor_valid = 1'b1;
            sensor       = ~v;
            @(negedge clk);
        end
        sensor_valid = 1'b0;
        resto_ready  = 1'b1;
        repeat (2) @(negedge clk);

        // Reset on the third CALC cycle drops the operation
        send(W'(200), acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("midcalc_reset");
        @(negedge clk);
        rst = 1'b0;
        nv  = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (resto_valid) nv++;
        end
        chk("no_result_after_reset", nv, 0);
        send(W'(9), acc);

        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_scoreboard", sb.size(), 0);
        chk("result_count", n_results, 3 + 16 + 20 + 1 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
